// File: rtl/seq_muldiv32.sv
// seq_muldiv32: iterative shift-add multiply / restoring divide with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to add the sgn port for two's-complement operation.
module seq_muldiv32 #(
  parameter int WIDTH = 32,
  parameter int CW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             op,
  input  logic             start,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m_q, xa, yb, it_hi, it_lo, fin_hi, fin_lo;
  logic op_q, neg_hi, neg_lo, sx, sy, accept, dz;
  logic [WIDTH:0] sum, shl;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef MULDIV_SIGNED_EN
  assign sx = sgn & X[WIDTH-1];
  assign sy = sgn & Y[WIDTH-1];
`else
  assign sx = 1'b0;
  assign sy = 1'b0;
`endif
  assign xa = sx ? -X : X;
  assign yb = sy ? -Y : Y;
  assign accept = start && (state == IDLE || state == HOLD);
  assign dz = op && Y == '0;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? (dz ? DONE : RUN) :
                state == RUN ? (cnt == '0 ? DONE : RUN) :
                state == DONE ? HOLD : state;
  end
  // One iteration of either algorithm; the last one also applies the sign fix-up.
  always_comb begin
    sum = {1'b0, hi} + {1'b0, (lo[0] ? m_q : '0)};
    shl = {hi, lo[WIDTH-1]};
    diff = {1'b0, shl} - {2'b0, m_q};
    it_hi = op_q ? (diff[WIDTH+1] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    it_lo = op_q ? {lo[WIDTH-2:0], ~diff[WIDTH+1]} : {sum[0], lo[WIDTH-1:1]};
    prod_neg = -{it_hi, it_lo};
    fin_hi = op_q ? (neg_hi ? -it_hi : it_hi) : (neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : it_hi);
    fin_lo = neg_lo ? (op_q ? -it_lo : prod_neg[WIDTH-1:0]) : it_lo;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      m_q <= '0;
      op_q <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
    end else begin
      busy <= state == RUN;
      done <= state == DONE;
      if (accept) begin
        op_q <= op;
        div0 <= dz;
        cnt <= CW'(WIDTH - 1);
        m_q <= op ? yb : xa;
        hi <= dz ? X : '0;
        lo <= dz ? '1 : op ? xa : yb;
        neg_hi <= sx;
        neg_lo <= sx ^ sy;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        hi <= cnt == '0 ? fin_hi : it_hi;
        lo <= cnt == '0 ? fin_lo : it_lo;
      end
    end
endmodule

// File: tb/tb_seq_muldiv32.sv
// tb_seq_muldiv32: directed vectors against an arithmetic reference model of seq_muldiv32.
// Build with MULDIV_SIGNED_EN to include the signed vectors.
module tb_seq_muldiv32;
  logic clk = 0, rst_n = 0, op = 0, start = 0, sgn = 0;
  logic [31:0] X = 0, Y = 0;
  logic busy, done, div0;
  logic [31:0] hi, lo;
  int n_vec = 0, n_bad = 0, cyc = 0, st = 0;
  seq_muldiv32 dut (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .op(op), .start(start),
`ifdef MULDIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h want %h", nm, cyc, a, e);
    end
  endtask
  function automatic void calc(input logic [31:0] x, input logic [31:0] y, input logic o,
                               input logic s, output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    if (o && y == 0) begin h = x; l = '1; end
    else if (!o) begin
      p = s ? 64'(longint'($signed(x)) * longint'($signed(y))) : 64'(x) * 64'(y);
      h = p[63:32]; l = p[31:0];
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 0; end
    else if (s) begin l = $signed(x) / $signed(y); h = $signed(x) % $signed(y); end
    else begin l = x / y; h = x % y; end
  endfunction
  // Reference model: acceptance window and latency from the handshake timing rules.
  bit active = 0, dz = 0, rv = 0;
  int n_start = 0, ign = 0;
  logic [31:0] e_hi = 0, e_lo = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      active = 0; rv = 1; e_hi = 0; e_lo = 0; dz = 0;
    end else if (start && (!active || cyc > ign)) begin
      active = 1; n_start = cyc; rv = 0; dz = op && Y == 0;
      ign = dz ? cyc + 1 : cyc + 33;
      calc(X, Y, op, sgn, e_hi, e_lo);
    end
    if (active && cyc == ign) rv = 1;
  end
  always @(negedge clk)
    if (cyc > 0) begin
      chk("busy", {31'b0, busy}, {31'b0, active && !dz && cyc >= n_start + 1 && cyc <= n_start + 32});
      chk("done", {31'b0, done}, {31'b0, active && cyc == ign});
      chk("div0", {31'b0, div0}, {31'b0, active && dz});
      if (rv) begin
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
      end
    end
  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic o, input logic s);
    @(negedge clk);
    X = x; Y = y; op = o; sgn = s; start = 1;
    @(negedge clk);
    start = 0;
    st = cyc;
  endtask
  task automatic pulse(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    X = x; Y = y; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string nm, input int lat, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    int k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: done not seen after %0d cycles", nm, k);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - st), 32'(lat));
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
      chk({nm, "_div0"}, {31'b0, div0}, {31'b0, ed});
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (50) @(negedge clk);
    chk("idle_hi", hi, 32'h0);
    chk("idle_lo", lo, 32'h0);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    wait_done("mul_max", 33, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    go(32'd6, 32'd7, 0, 0);
    wait_done("mul_6x7", 33, 32'h0, 32'd42, 0);
    go(32'd100, 32'd7, 1, 0);
    wait_done("div_100_7", 33, 32'd2, 32'd14, 0);
    go(32'd5, 32'd0, 1, 0);
    wait_done("div_by0", 1, 32'd5, 32'hFFFF_FFFF, 1);
    go(32'h0001_0000, 32'h0003_0000, 0, 0);
    repeat (3) @(negedge clk);
    pulse(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (13) @(negedge clk);
    pulse(32'h0000_0009, 32'h0000_0009);
    wait_done("mul_restart", 33, 32'h0000_0003, 32'h0, 0);
    repeat (3) @(negedge clk);
    chk("hold_done", {31'b0, done}, 32'h0);
    go(32'hFFFF_0000, 32'd3, 1, 0);
    repeat (15) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    go(32'h1234_5678, 32'h10, 1, 0);
    wait_done("div_after_rst", 33, 32'd8, 32'h0123_4567, 0);
`ifdef MULDIV_SIGNED_EN
    go(-32'sd6, 32'd4, 1, 1);
    wait_done("sdiv", 33, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    go(-32'sd3, 32'd5, 0, 1);
    wait_done("smul", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
    wait_done("sdiv_ovf", 33, 32'h0, 32'h8000_0000, 0);
    go(-32'sd7, 32'd0, 1, 1);
    wait_done("sdiv_by0", 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
